pipelined_decode_ctrl: RTL and testbench

//  Parametrised successor of the single-cycle control decoder: decodes OPC_W-bit opcodes

---
 rtl/pipelined_decode_ctrl_if.sv | 41 ++++
 rtl/pipelined_decode_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipelined_decode_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pipelined_decode_ctrl_if.sv
// Handshake and ID/EX bundle between fetch, the decode stage and the ALU/memory stage.
// The decoder uses the slave modport; the environment driving fetch/downstream uses master.
interface pipelined_decode_ctrl_if #(
    parameter int INSTR_W = 24,
    parameter int OPC_W   = 4,
    parameter int REG_AW  = 4,
    parameter int ALUOP_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic               reg_dst;
    logic               jump;
    logic               branch;
    logic               mem_read;
    logic               mem_to_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [ALUOP_W-1:0] alu_op;
    logic [OPC_W-1:0]   opcode;
    logic [REG_AW-1:0]  rs;
    logic [REG_AW-1:0]  rt;
    logic [REG_AW-1:0]  rd;
    logic               illegal;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, reg_dst, jump, branch, mem_read, mem_to_reg,
               mem_write, alu_src, reg_write, alu_op, opcode, rs, rt, rd, illegal
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, reg_dst, jump, branch, mem_read, mem_to_reg,
               mem_write, alu_src, reg_write, alu_op, opcode, rs, rt, rd, illegal
    );
endinterface

// File: rtl/pipelined_decode_ctrl.sv
// Decode stage: opcode -> control bundle registered into ID/EX with valid/ready, load-use
// bubbling, jump-shadow squashing and flush. DECODE_PERF_EN adds bubble/squash counters.
module pipelined_decode_ctrl #(
    parameter int INSTR_W    = 24,
    parameter int OPC_W      = 4,
    parameter int REG_AW     = 4,
    parameter int ALUOP_W    = 4,
    parameter int JUMP_SLOTS = 1
) (
    input  logic clk,
    input  logic rst_n,
    pipelined_decode_ctrl_if.slave bus
`ifdef DECODE_PERF_EN
    ,
    output logic [15:0] bubble_cnt,
    output logic [15:0] squash_cnt
`endif
);
    localparam int RS_LSB = INSTR_W - OPC_W - REG_AW;
    localparam int RT_LSB = RS_LSB - REG_AW;
    localparam int RD_LSB = RT_LSB - REG_AW;

    localparam logic [OPC_W-1:0] OPC_R  = OPC_W'(4'b0001);
    localparam logic [OPC_W-1:0] OPC_I  = OPC_W'(4'b0010);
    localparam logic [OPC_W-1:0] OPC_BR = OPC_W'(4'b1000);
    localparam logic [OPC_W-1:0] OPC_J  = OPC_W'(4'b0100);
    localparam logic [OPC_W-1:0] OPC_LD = OPC_W'(4'b1100);
    localparam logic [OPC_W-1:0] OPC_ST = OPC_W'(4'b0011);

    localparam logic [2:0] SHADOW_INIT = 3'(JUMP_SLOTS);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    typedef struct packed {
        logic               reg_dst;
        logic               jump;
        logic               branch;
        logic               mem_read;
        logic               mem_to_reg;
        logic               mem_write;
        logic               alu_src;
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
        logic               illegal;
    } ctrl_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [OPC_W-1:0]   opcode_q, opcode_d;
    logic [REG_AW-1:0]  rs_q, rs_d;
    logic [REG_AW-1:0]  rt_q, rt_d;
    logic [REG_AW-1:0]  rd_q, rd_d;
    logic [2:0]         cnt_q, cnt_d;

    logic [OPC_W-1:0]   in_opc;
    logic [REG_AW-1:0]  in_rs;
    logic [REG_AW-1:0]  in_rt;
    logic [REG_AW-1:0]  in_rd;
    logic [ALUOP_W-1:0] in_funct;
    ctrl_t              ctrl_in;
    logic               in_uses_rt;
    logic               shadow;
    logic               hazard;
    logic               stage_free;
    logic               in_ready;
    logic               accept;
    logic               bubble_evt;
    logic               squash_evt;

    assign in_opc   = bus.instr[INSTR_W-1 -: OPC_W];
    assign in_rs    = bus.instr[RS_LSB +: REG_AW];
    assign in_rt    = bus.instr[RT_LSB +: REG_AW];
    assign in_rd    = bus.instr[RD_LSB +: REG_AW];
    assign in_funct = bus.instr[ALUOP_W-1:0];

    always_comb begin
        ctrl_in = '0;
        case (in_opc)
            OPC_R: begin
                ctrl_in.reg_dst   = 1'b1;
                ctrl_in.reg_write = 1'b1;
                ctrl_in.alu_op    = in_funct;
            end
            OPC_I: begin
                ctrl_in.reg_write = 1'b1;
                ctrl_in.alu_src   = 1'b1;
                ctrl_in.alu_op    = in_funct;
            end
            OPC_BR: begin
                ctrl_in.branch = 1'b1;
                ctrl_in.alu_op = ALUOP_W'(4'b0010);
            end
            OPC_J: begin
                ctrl_in.jump      = 1'b1;
                ctrl_in.reg_write = 1'b1;
                ctrl_in.alu_src   = 1'b1;
            end
            OPC_LD: begin
                ctrl_in.reg_write  = 1'b1;
                ctrl_in.mem_read   = 1'b1;
                ctrl_in.mem_to_reg = 1'b1;
                ctrl_in.alu_op     = ALUOP_W'(4'b0001);
            end
            OPC_ST: begin
                ctrl_in.mem_write = 1'b1;
                ctrl_in.alu_op    = ALUOP_W'(4'b0001);
            end
            default: ctrl_in.illegal = 1'b1;
        endcase
    end

    // Only R, BR and ST read rt as a source; the others write it or ignore it.
    assign in_uses_rt = (in_opc == OPC_R) || (in_opc == OPC_BR) || (in_opc == OPC_ST);
    assign shadow     = (cnt_q != 3'd0);

    // Instructions falling into a jump shadow are discarded, so they can never stall on a load.
    assign hazard = bus.in_valid && !shadow && out_valid_q && ctrl_q.mem_read &&
                    (rt_q != '0) &&
                    ((rt_q == in_rs) || (in_uses_rt && (rt_q == in_rt)));

    assign stage_free = !out_valid_q || bus.out_ready;
    assign in_ready   = rst_n && stage_free && (state_q == ST_RUN) && !hazard;
    assign accept     = bus.in_valid && in_ready;

    always_comb begin
        state_d     = ST_RUN;
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        opcode_d    = opcode_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        bubble_evt  = 1'b0;
        squash_evt  = 1'b0;

        if (bus.flush) begin
            out_valid_d = 1'b0;
            cnt_d       = 3'd0;
            squash_evt  = bus.in_valid;
        end else if ((state_q == ST_RUN) && hazard && stage_free) begin
            out_valid_d = 1'b0;
            state_d     = ST_BUBBLE;
            bubble_evt  = 1'b1;
        end else if (accept) begin
            if (shadow) begin
                out_valid_d = 1'b0;
                cnt_d       = cnt_q - 3'd1;
                squash_evt  = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                ctrl_d      = ctrl_in;
                opcode_d    = in_opc;
                rs_d        = in_rs;
                rt_d        = in_rt;
                rd_d        = in_rd;
                if (ctrl_in.jump) begin
                    cnt_d = SHADOW_INIT;
                end
            end
        end else if (stage_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            opcode_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= 3'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            opcode_q    <= opcode_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef DECODE_PERF_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (bubble_evt && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
        if (squash_evt && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= 16'd0;
            squash_cnt_q <= 16'd0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    logic unused_perf_evt;
    assign unused_perf_evt = bubble_evt ^ squash_evt;
`endif

    // Bits between rd and funct carry no control meaning.
    logic unused_instr;
    assign unused_instr = ^bus.instr;

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.reg_dst    = ctrl_q.reg_dst;
    assign bus.jump       = ctrl_q.jump;
    assign bus.branch     = ctrl_q.branch;
    assign bus.mem_read   = ctrl_q.mem_read;
    assign bus.mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.mem_write  = ctrl_q.mem_write;
    assign bus.alu_src    = ctrl_q.alu_src;
    assign bus.reg_write  = ctrl_q.reg_write;
    assign bus.alu_op     = ctrl_q.alu_op;
    assign bus.illegal    = ctrl_q.illegal;
    assign bus.opcode     = opcode_q;
    assign bus.rs         = rs_q;
    assign bus.rt         = rt_q;
    assign bus.rd         = rd_q;
endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Directed bench for pipelined_decode_ctrl: a decode-table model fills a scoreboard as
// instructions are accepted; ID/EX contents are compared when downstream consumes them.
module tb_pipelined_decode_ctrl;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [28:0] sb[$];

`ifdef DECODE_PERF_EN
    logic [15:0] bubble_cnt;
    logic [15:0] squash_cnt;
`endif

    pipelined_decode_ctrl_if #(.INSTR_W(24), .OPC_W(4), .REG_AW(4), .ALUOP_W(4)) bus ();

    pipelined_decode_ctrl #(
        .INSTR_W(24), .OPC_W(4), .REG_AW(4), .ALUOP_W(4), .JUMP_SLOTS(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef DECODE_PERF_EN
        ,
        .bubble_cnt (bubble_cnt),
        .squash_cnt (squash_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {opcode, rs, rt, rd, reg_dst, jump, branch, mem_read, mem_to_reg, mem_write,
    //  alu_src, reg_write, alu_op, illegal}
    function automatic logic [28:0] model(input logic [23:0] ins);
        logic [3:0] op;
        logic [7:0] ctl;
        logic [3:0] alu;
        logic       ill;
        op  = ins[23:20];
        ctl = 8'h00;
        alu = 4'h0;
        ill = 1'b0;
        case (op)
            4'h1: begin ctl = 8'b1000_0001; alu = ins[3:0]; end
            4'h2: begin ctl = 8'b0000_0011; alu = ins[3:0]; end
            4'h8: begin ctl = 8'b0010_0000; alu = 4'h2;     end
            4'h4: begin ctl = 8'b0100_0011; alu = 4'h0;     end
            4'hC: begin ctl = 8'b0001_1001; alu = 4'h1;     end
            4'h3: begin ctl = 8'b0000_0100; alu = 4'h1;     end
            default: ill = 1'b1;
        endcase
        return {op, ins[19:16], ins[15:12], ins[11:8], ctl, alu, ill};
    endfunction

    function automatic logic [28:0] pack_out();
        return {bus.opcode, bus.rs, bus.rt, bus.rd, bus.reg_dst, bus.jump, bus.branch,
                bus.mem_read, bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write,
                bus.alu_op, bus.illegal};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drive one cycle of inputs, check mid-cycle, then advance.
    task automatic step(input logic v, input logic [23:0] ins, input logic fl,
                        input logic ordy, input logic exp_ready, input logic exp_ov,
                        input logic push);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #3;
        check("in_ready", bus.in_ready, exp_ready);
        check("out_valid", bus.out_valid, exp_ov);
        if (push) sb.push_back(model(ins));
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL payload: observed output %0h expected scoreboard entry, queue empty",
                       pack_out());
            end else if (ordy) begin
                check("payload", pack_out(), sb.pop_front());
            end else begin
                check("hold", pack_out(), sb[0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 24'h0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_payload", pack_out(), 29'h0);
        rst_n = 1'b1;

        // R-type issue: reg_dst, reg_write, alu_op=5, rd=3
        step(1'b1, 24'h112305, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        // load to r0 never causes a hazard
        step(1'b1, 24'hC00000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 24'h100105, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // load-use via rs: one bubble then R issues
        step(1'b1, 24'hC02000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 24'h123406, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'h123406, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h123406, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef DECODE_PERF_EN
        check("bubble_cnt", bubble_cnt, 16'd1);
`endif

        // jump shadow: R after J dropped, following I issues
        step(1'b1, 24'h412300, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 24'h112307, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 24'h256709, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef DECODE_PERF_EN
        check("squash_cnt", squash_cnt, 16'd1);
`endif

        // rt match: I ignores rt (no hazard), ST reads rt (hazard)
        step(1'b1, 24'hC03000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 24'h213456, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 24'hC03000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 24'h313000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'h313000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 24'h313000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // stall for 3 cycles, then flush clears the stage
        step(1'b1, 24'h312000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 24'h256709, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'h256709, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'h256709, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 24'h256709, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        if (sb.size() > 0) sb.delete(0);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // flush beats a jump accept: no shadow afterwards; then an illegal opcode
        step(1'b1, 24'h412300, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 24'h112305, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 24'hF12345, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        // asynchronous reset mid-stream
        step(1'b1, 24'h256709, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b0);
        check("midrst_payload", pack_out(), 29'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef DECODE_PERF_EN
        check("rst_bubble_cnt", bubble_cnt, 16'd0);
        check("rst_squash_cnt", squash_cnt, 16'd0);
`endif
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 24'h112305, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
